// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: default widths, client indices and read-return tag type shared by the RAM arbiter files
package ram_arb_pkg;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;
  typedef struct packed {
    logic valid;
    logic client;
  } rd_tag_t;
endpackage

// File: rtl/ram_dp_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; req_i requests, en_i gates grants, pick_o the would-be winner, gnt_o the grant
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] pick_o,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;
  always_comb begin
    pick_o = (req_i == 2'b11) ? (ptr_q == CLI1 ? 2'b01 : 2'b10) : req_i;
    gnt_o = en_i ? pick_o : 2'b00;
    ptr_d = gnt_o[1] ? CLI1 : gnt_o[0] ? CLI0 : ptr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= CLI1;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/ram_dp_arbiter.sv
// ram_dp_arbiter: two clients share a simple dual-port RAM with round-robin per port and tagged read return
// ports: cN_wr_*/cN_rd_* client handshakes (N=0,1), rd_data shared read bus, ram_* registered RAM side, ram_q RAM data
module ram_dp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_wr_req,
  input  logic [AW-1:0] c0_wr_addr,
  input  logic [DW-1:0] c0_wr_data,
  output logic          c0_wr_gnt,
  input  logic          c0_rd_req,
  input  logic [AW-1:0] c0_rd_addr,
  output logic          c0_rd_gnt,
  output logic          c0_rd_valid,
  input  logic          c1_wr_req,
  input  logic [AW-1:0] c1_wr_addr,
  input  logic [DW-1:0] c1_wr_data,
  output logic          c1_wr_gnt,
  input  logic          c1_rd_req,
  input  logic [AW-1:0] c1_rd_addr,
  output logic          c1_rd_gnt,
  output logic          c1_rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          ram_wren,
  output logic [AW-1:0] ram_wraddress,
  output logic [DW-1:0] ram_data,
  output logic          ram_rden,
  output logic [AW-1:0] ram_rdaddress,
  input  logic [DW-1:0] ram_q
);
  logic [1:0] wr_pick, wr_gnt, rd_pick, rd_gnt;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;
  logic collide;
  rd_tag_t tag_d;
  rd_tag_t [RD_LAT:0] tag_q;
  rr_arb2 u_wr_arb (
    .clk(clk), .rst(rst), .req_i({c1_wr_req, c0_wr_req}), .en_i(1'b1), .pick_o(wr_pick), .gnt_o(wr_gnt)
  );
  // a read hitting the address written this cycle would sample stale RAM data, so hold it back a cycle
  rr_arb2 u_rd_arb (
    .clk(clk), .rst(rst), .req_i({c1_rd_req, c0_rd_req}), .en_i(~collide), .pick_o(rd_pick), .gnt_o(rd_gnt)
  );
  always_comb begin
    wa = wr_pick[1] ? c1_wr_addr : c0_wr_addr;
    wd = wr_pick[1] ? c1_wr_data : c0_wr_data;
    ra = rd_pick[1] ? c1_rd_addr : c0_rd_addr;
    collide = |wr_gnt && |rd_pick && ra == wa;
  end
  assign tag_d = '{valid: |rd_gnt, client: rd_gnt[1]};
  assign {c1_wr_gnt, c0_wr_gnt} = wr_gnt;
  assign {c1_rd_gnt, c0_rd_gnt} = rd_gnt;
  assign c0_rd_valid = tag_q[RD_LAT].valid && tag_q[RD_LAT].client == CLI0;
  assign c1_rd_valid = tag_q[RD_LAT].valid && tag_q[RD_LAT].client == CLI1;
  assign rd_data = ram_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ram_wren <= 1'b0;
      ram_wraddress <= '0;
      ram_data <= '0;
      ram_rden <= 1'b0;
      ram_rdaddress <= '0;
      tag_q <= '0;
    end else begin
      ram_wren <= |wr_gnt;
      ram_rden <= |rd_gnt;
      if (|wr_gnt) begin
        ram_wraddress <= wa;
        ram_data <= wd;
      end
      if (|rd_gnt) ram_rdaddress <= ra;
      tag_q <= {tag_q[RD_LAT-1:0], tag_d};
    end
endmodule

// File: tb/tb_ram_dp_arbiter.sv
// tb_ram_dp_arbiter: random and directed traffic against a transaction-level model of the shared RAM arbiter
module tb_ram_dp_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RD_LAT = 1;
  typedef struct { int due; int cl; logic [DW-1:0] d; } exp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] wreq = '0, rreq = '0;
  logic [AW-1:0] waddr [2] = '{default: '0};
  logic [AW-1:0] raddr [2] = '{default: '0};
  logic [DW-1:0] wdata [2] = '{default: '0};
  logic c0_wr_gnt, c0_rd_gnt, c0_rd_valid, c1_wr_gnt, c1_rd_gnt, c1_rd_valid;
  logic [DW-1:0] rd_data, ram_data, ram_q;
  logic ram_wren, ram_rden;
  logic [AW-1:0] ram_wraddress, ram_rdaddress;
  logic [DW-1:0] mem [2**AW] = '{default: '0};
  logic [DW-1:0] qp [RD_LAT] = '{default: '0};
  logic [DW-1:0] shadow [2**AW] = '{default: '0};
  op_t wq [2][$];
  op_t rq [2][$];
  exp_t sb [$];
  int checks = 0, errors = 0, cyc = 0, gap = 0;
  int wlast = 1, rlast = 1, last_wg = -1, last_rg = -1;
  logic p_wren = 1'b0, p_rden = 1'b0;
  logic [AW-1:0] p_wa = '0, p_ra = '0;
  logic [DW-1:0] p_wd = '0, obs_d = '0;
  logic [1:0] obs_v = '0;

  ram_dp_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .c0_wr_req(wreq[0]), .c0_wr_addr(waddr[0]), .c0_wr_data(wdata[0]), .c0_wr_gnt(c0_wr_gnt),
    .c0_rd_req(rreq[0]), .c0_rd_addr(raddr[0]), .c0_rd_gnt(c0_rd_gnt), .c0_rd_valid(c0_rd_valid),
    .c1_wr_req(wreq[1]), .c1_wr_addr(waddr[1]), .c1_wr_data(wdata[1]), .c1_wr_gnt(c1_wr_gnt),
    .c1_rd_req(rreq[1]), .c1_rd_addr(raddr[1]), .c1_rd_gnt(c1_rd_gnt), .c1_rd_valid(c1_rd_valid),
    .rd_data(rd_data), .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    qp[0] <= mem[ram_rdaddress];
    for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
  end
  assign ram_q = qp[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [1:0] req, input int last);
    if (req == 2'b11) return 1 - last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] oh(input int c);
    return (c == 0) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00;
  endfunction

  function automatic op_t mk(input int a, input int d);
    op_t o;
    o.a = AW'(a);
    o.d = DW'(d);
    return o;
  endfunction

  function automatic int pending();
    return wq[0].size() + wq[1].size() + rq[0].size() + rq[1].size() + sb.size()
         + int'(wreq[0]) + int'(wreq[1]) + int'(rreq[0]) + int'(rreq[1]);
  endfunction

  task automatic load();
    op_t o;
    for (int c = 0; c < 2; c++) begin
      if (!wreq[c] && wq[c].size() > 0 && int'($urandom_range(99)) >= gap) begin
        o = wq[c].pop_front();
        wreq[c] = 1'b1;
        waddr[c] = o.a;
        wdata[c] = o.d;
      end
      if (!rreq[c] && rq[c].size() > 0 && int'($urandom_range(99)) >= gap) begin
        o = rq[c].pop_front();
        rreq[c] = 1'b1;
        raddr[c] = o.a;
      end
    end
  endtask

  task automatic step();
    int ew, rp, er;
    exp_t e;
    logic [1:0] ev;
    load();
    @(negedge clk);
    ew = pick(wreq, wlast);
    rp = pick(rreq, rlast);
    er = (ew >= 0 && rp >= 0 && raddr[rp] == waddr[ew]) ? -1 : rp;
    check("wr_gnt", 32'({c1_wr_gnt, c0_wr_gnt}), 32'(oh(ew)));
    check("rd_gnt", 32'({c1_rd_gnt, c0_rd_gnt}), 32'(oh(er)));
    check("ram_wren", 32'(ram_wren), 32'(p_wren));
    if (p_wren) begin
      check("ram_wraddress", 32'(ram_wraddress), 32'(p_wa));
      check("ram_data", 32'(ram_data), 32'(p_wd));
    end
    check("ram_rden", 32'(ram_rden), 32'(p_rden));
    if (p_rden) check("ram_rdaddress", 32'(ram_rdaddress), 32'(p_ra));
    ev = 2'b00;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      ev = oh(e.cl);
      check("rd_data", 32'(rd_data), 32'(e.d));
    end
    check("rd_valid", 32'({c1_rd_valid, c0_rd_valid}), 32'(ev));
    obs_v = {c1_rd_valid, c0_rd_valid};
    obs_d = rd_data;
    p_wren = ew >= 0;
    p_rden = er >= 0;
    if (ew >= 0) begin
      p_wa = waddr[ew];
      p_wd = wdata[ew];
      shadow[waddr[ew]] = wdata[ew];
      wlast = ew;
    end
    if (er >= 0) begin
      p_ra = raddr[er];
      e.due = cyc + RD_LAT + 1;
      e.cl = er;
      e.d = shadow[raddr[er]];
      sb.push_back(e);
      rlast = er;
    end
    last_wg = ew;
    last_rg = er;
    @(posedge clk);
    #1;
    cyc++;
    if (ew >= 0) wreq[ew] = 1'b0;
    if (er >= 0) rreq[er] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wreq = '0;
    rreq = '0;
    for (int c = 0; c < 2; c++) begin
      wq[c].delete();
      rq[c].delete();
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram", 32'({ram_wren, ram_wraddress, ram_data, ram_rden, ram_rdaddress}), 32'd0);
    check("rst_valid", 32'({c1_rd_valid, c0_rd_valid}), 32'd0);
    rst = 1'b0;
    sb.delete();
    wlast = 1;
    rlast = 1;
    p_wren = 1'b0;
    p_rden = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max);
    int n, busy;
    n = 0;
    do begin
      step();
      n++;
      busy = pending();
    end while (busy != 0 && n < max);
    check("drain_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, prev;
    do_reset();
    gap = 0;
    repeat (300) step();
    check("idle_ram", 32'({ram_wren, ram_wraddress, ram_data, ram_rden, ram_rdaddress}), 32'd0);

    wq[0].push_back(mk(20, 20));
    drain(20);
    rq[0].push_back(mk(20, 0));
    n = 0;
    do begin
      step();
      n++;
    end while (last_rg != 0 && n < 10);
    check("raw_rd_gnt", 32'(last_rg), 32'd0);
    repeat (RD_LAT + 1) step();
    check("raw_valid", 32'(obs_v), 32'd1);
    check("raw_data", 32'(obs_d), 32'd20);

    do_reset();
    for (int i = 0; i <= 20; i++) begin
      wq[0].push_back(mk(40 + i, (40 + i) ^ 'h3C));
      wq[1].push_back(mk(100 + i, (100 + i) ^ 'hC3));
    end
    for (int i = 0; i < 42; i++) begin
      step();
      check("wr_alternate", 32'(last_wg), 32'(i % 2));
    end
    drain(10);
    for (int i = 0; i <= 20; i++) begin
      check("mem_c0_seq", 32'(mem[40 + i]), 32'(8'(40 + i) ^ 8'h3C));
      check("mem_c1_seq", 32'(mem[100 + i]), 32'(8'(100 + i) ^ 8'hC3));
    end

    wq[1].push_back(mk(45, 'hA5));
    rq[0].push_back(mk(45, 0));
    step();
    check("coll_wr", 32'(last_wg), 32'd1);
    check("coll_blocked", 32'(last_rg), 32'(-1));
    step();
    check("coll_retry", 32'(last_rg), 32'd0);
    repeat (RD_LAT + 1) step();
    check("coll_valid", 32'(obs_v), 32'd1);
    check("coll_data", 32'(obs_d), 32'hA5);

    wq[0].push_back(mk(70, 'h17));
    wq[0].push_back(mk(71, 'h71));
    drain(20);
    for (int i = 0; i < 12; i++) begin
      rq[0].push_back(mk(70, 0));
      rq[1].push_back(mk(71, 0));
    end
    prev = -1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (i > 0) check("rd_alternate", 32'(last_rg), 32'(1 - prev));
      if (i > RD_LAT) check("rd_stream", 32'(obs_v != 2'b00), 32'd1);
      prev = last_rg;
    end
    drain(10);

    gap = 30;
    for (int i = 0; i < 300; i++)
      for (int c = 0; c < 2; c++) begin
        wq[c].push_back(mk(int'($urandom_range(7)), int'($urandom_range(255))));
        rq[c].push_back(mk(int'($urandom_range(7)), 0));
      end
    drain(5000);
    gap = 0;

    do_reset();
    rq[0].push_back(mk(20, 0));
    step();
    check("flight_gnt", 32'(last_rg), 32'd0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check("flight_dropped", 32'(obs_v), 32'd0);
    end
    wq[0].push_back(mk(5, 1));
    wq[1].push_back(mk(6, 2));
    step();
    check("post_rst_first", 32'(last_wg), 32'd0);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
